// File: rtl/control_unit.sv
// Instruction decoder for the single-cycle RV32I datapath.
// Decode outputs are purely combinational; illegal_seen is a sticky flag
// that records any unsupported encoding observed since reset.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic [1:0] imm_sel,
  output logic       pc_sel,
  output logic [1:0] reg_we,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       mem_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       illegal_seen
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  localparam logic [1:0] RW_NONE = 2'd0;
  localparam logic [1:0] RW_ALU  = 2'd1;
  localparam logic [1:0] RW_LOAD = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Base ALU operation selected by funct3 (funct7 variants handled by caller).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_from_f3 = ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  // Main decode; an illegal encoding collapses every select to a NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I;
    pc_sel    = 1'b0;
    reg_we    = RW_NONE;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    mem_we    = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;

    case (opcode)
      OPC_R: begin
        reg_we = RW_ALU;
        if (funct7 == F7_BASE) begin
          alu_op = alu_from_f3(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_IMM: begin
        reg_we    = RW_ALU;
        alu_b_sel = 1'b1;
        imm_sel   = IMM_I;
        alu_op    = alu_from_f3(funct3);
        if (funct3 == 3'b001) begin
          if (funct7 != F7_BASE) illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) alu_op = ALU_SRA;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        alu_b_sel = 1'b1;
        imm_sel   = IMM_I;
        reg_we    = RW_LOAD;
        wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        alu_b_sel = 1'b1;
        imm_sel   = IMM_S;
        mem_we    = 1'b1;
      end
      OPC_BRANCH: begin
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        imm_sel   = IMM_B;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      OPC_JAL: begin
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        imm_sel   = IMM_J;
        pc_sel    = 1'b1;
        reg_we    = RW_ALU;
        wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        alu_b_sel = 1'b1;
        imm_sel   = IMM_I;
        pc_sel    = 1'b1;
        reg_we    = RW_ALU;
        wb_sel    = WB_PC4;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_op    = ALU_ADD;
      imm_sel   = IMM_I;
      pc_sel    = 1'b0;
      reg_we    = RW_NONE;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      mem_we    = 1'b0;
      wb_sel    = WB_ALU;
    end
  end

  // Sticky illegal flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       illegal_seen <= 1'b0;
    else if (illegal) illegal_seen <= 1'b1;
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes model expectations,
// a monitor on the falling clock edge pops and compares.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic [3:0] alu_op;
  logic [1:0] imm_sel;
  logic       pc_sel;
  logic [1:0] reg_we;
  logic       alu_a_sel;
  logic       alu_b_sel;
  logic       mem_we;
  logic [1:0] wb_sel;
  logic       illegal;
  logic       illegal_seen;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_op(alu_op), .imm_sel(imm_sel), .pc_sel(pc_sel), .reg_we(reg_we),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .mem_we(mem_we),
    .wb_sel(wb_sel), .illegal(illegal), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] dec;   // {alu,imm,pc,rw,a,b,mem,wb,ill}
    logic        seen;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   model_seen = 1'b0;

  int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  int legal_ops[7] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6f, 'h67};

  // Reference decode from the instruction-class rules.
  function automatic logic [14:0] ref_dec(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    int alu = 0, imm = 0, pc = 0, rw = 0, a = 0, b = 0, mem = 0, wb = 0;
    bit ok = 1'b1;
    case (op)
      7'h33: begin
        rw = 1;
        if (f7 == 7'h00) alu = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 7;
        else ok = 1'b0;
      end
      7'h13: begin
        rw = 1; b = 1;
        alu = alu_tab[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) alu = 7;
          else if (f7 != 7'h00) ok = 1'b0;
        end
      end
      7'h03: begin b = 1; rw = 2; wb = 1; end
      7'h23: begin b = 1; imm = 1; mem = 1; end
      7'h63: begin a = 1; b = 1; imm = 2; ok = (f3 != 3'd2) && (f3 != 3'd3); end
      7'h6f: begin a = 1; b = 1; imm = 3; pc = 1; rw = 1; wb = 2; end
      7'h67: begin b = 1; pc = 1; rw = 1; wb = 2; ok = (f3 == 3'd0); end
      default: ok = 1'b0;
    endcase
    if (!ok) return 15'h0001;
    return {4'(alu), 2'(imm), 1'(pc), 2'(rw), 1'(a), 1'(b), 1'(mem), 2'(wb), 1'b0};
  endfunction

  // Apply one vector for one clock cycle, optionally pulsing reset within it.
  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit do_rst);
    exp_t e;
    @(posedge clk);
    #2;
    opcode = op; funct3 = f3; funct7 = f7;
    if (do_rst) rst_n = 1'b0;
    e.dec = ref_dec(op, f3, f7);
    e.seen = do_rst ? 1'b0 : model_seen;
    e.op = op; e.f3 = f3; e.f7 = f7;
    q.push_back(e);
    // Reset is released before the next rising edge, so that edge captures this vector.
    model_seen = do_rst ? e.dec[0] : (model_seen | e.dec[0]);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
  initial begin
    exp_t e;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {alu_op, imm_sel, pc_sel, reg_we, alu_a_sel, alu_b_sel, mem_we, wb_sel, illegal};
        n_tests++;
        if (act !== e.dec) begin
          n_fail++;
          $display("FAIL decode op=%b f3=%b f7=%b: got %h expected %h",
                   e.op, e.f3, e.f7, act, e.dec);
        end
        n_tests++;
        if (illegal_seen !== e.seen) begin
          n_fail++;
          $display("FAIL illegal_seen op=%b f3=%b f7=%b: got %b expected %b",
                   e.op, e.f3, e.f7, illegal_seen, e.seen);
        end
      end
    end
  end

  // Stimulus: directed test-plan vectors, then randomized traffic with reset pulses.
  initial begin
    logic [6:0] op;
    logic [6:0] f7;
    int r;
    int waited;
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b1);  // reset state, ADD
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b0);  // ADD
    apply(7'b0110011, 3'b000, 7'b0100000, 1'b0);  // SUB
    apply(7'b0010011, 3'b000, 7'b1010101, 1'b0);  // ADDI, funct7 ignored
    apply(7'b0010011, 3'b101, 7'b0100000, 1'b0);  // SRAI
    apply(7'b0000011, 3'b010, 7'b0000000, 1'b0);  // LW
    apply(7'b0100011, 3'b010, 7'b0000000, 1'b0);  // SW
    apply(7'b1100011, 3'b000, 7'b0000000, 1'b0);  // BEQ
    apply(7'b1100011, 3'b010, 7'b0000000, 1'b0);  // illegal branch funct3
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b1);  // reset clears flag mid-cycle
    apply(7'b1101111, 3'b011, 7'b1111111, 1'b0);  // JAL
    apply(7'b1100111, 3'b000, 7'b0000000, 1'b0);  // JALR
    apply(7'b1100111, 3'b001, 7'b0000000, 1'b0);  // JALR bad funct3
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b1);  // reset
    apply(7'b1111111, 3'b000, 7'b0000000, 1'b0);  // unknown opcode
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b0);  // ADD, flag now set
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b0);  // flag holds
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b1);  // reset clears immediately
    apply(7'b0110011, 3'b010, 7'b0100000, 1'b0);  // R-type alt funct7 bad funct3
    apply(7'b0010011, 3'b001, 7'b0100000, 1'b0);  // SLLI bad funct7

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 7));
      op = (r == 7) ? 7'($urandom) : 7'(legal_ops[r]);
      r = int'($urandom_range(0, 3));
      f7 = (r == 0) ? 7'h20 : (r == 1) ? 7'($urandom) : 7'h00;
      apply(op, 3'($urandom), f7, ($urandom_range(0, 39) == 0));
    end

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Combinational instruction decoder for the softcore's single-cycle RV32I datapath. Converts `opcode`, `funct3` and `funct7` into ALU, immediate, PC, register-file, memory and write-back selects. A small clocked section records whether any illegal encoding has been decoded since reset.

## Interface
Parameters: none.

- `clk`  in  1  system clock; used only by the sticky illegal flag
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  7  instruction[6:0]
- `funct3`  in  3  instruction[14:12]
- `funct7`  in  7  instruction[31:25]
- `alu_op`  out  4  ALU operation:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
- `imm_sel`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- `pc_sel`  out  1  1 = next PC comes from the ALU result (jumps); 0 = PC+4. The branch-taken override is external.
- `reg_we`  out  2  register write: 00 none, 01 write this cycle, 10 load write (data from memory)
- `alu_a_sel`  out  1  0 = rs1, 1 = PC
- `alu_b_sel`  out  1  0 = rs2, 1 = immediate
- `mem_we`  out  1  data-memory write enable
- `wb_sel`  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4
- `illegal`  out  1  current encoding is unsupported (combinational)
- `illegal_seen`  out  1  sticky, registered; set on any cycle where `illegal`=1

## Operation
Every output except `illegal_seen` is a pure combinational function of `opcode`, `funct3` and `funct7`. Any output not listed for a row below is 0.

- **R-type (0110011):**
  - `reg_we`=01, `wb_sel`=00, `alu_a_sel`=0, `alu_b_sel`=0.
  - `funct7`=0000000: `funct3` 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - `funct7`=0100000: `funct3` 000 SUB, 101 SRA; any other `funct3` is illegal.
  - Any other `funct7` is illegal.
- **OP-IMM (0010011):**
  - `reg_we`=01, `alu_b_sel`=1, `imm_sel`=00.
  - ALU op follows `funct3` as in R-type; `funct7` is ignored except for shifts.
  - 001 (SLLI) requires `funct7`=0000000.
  - 101 requires `funct7`=0000000 (SRL) or 0100000 (SRA).
  - Any other shift `funct7` is illegal.
- **LOAD (0000011):**
  - ADD, `alu_b_sel`=1, `imm_sel`=00, `reg_we`=10, `wb_sel`=01.
  - Every `funct3` is accepted; width handling is external.
- **STORE (0100011):** ADD, `alu_b_sel`=1, `imm_sel`=01, `mem_we`=1, `reg_we`=00.
- **BRANCH (1100011):**
  - ADD, `alu_a_sel`=1, `alu_b_sel`=1, `imm_sel`=10, `pc_sel`=0. The ALU computes the target.
  - No register write and no memory write.
  - `funct3` 010 and 011 are illegal.
- **JAL (1101111):** ADD, `alu_a_sel`=1, `alu_b_sel`=1, `imm_sel`=11, `pc_sel`=1, `reg_we`=01, `wb_sel`=10.
- **JALR (1100111, `funct3`=000):** ADD, `alu_a_sel`=0, `alu_b_sel`=1, `imm_sel`=00, `pc_sel`=1, `reg_we`=01, `wb_sel`=10.
- **Any other opcode, or an illegal sub-encoding:** `illegal`=1 and every other output is 0, which is a safe NOP: no register write, no memory write, no jump.
- **`illegal_seen`:**
  - Set on the `clk` rising edge while `illegal`=1.
  - Holds at 1 until `rst_n` is asserted.
  - No other clear path exists.

## Timing
- Decode outputs settle within one combinational delay of an input change. They have no clock latency.
- Decode outputs are unaffected by `rst_n`; they keep decoding while reset is asserted.
- `illegal_seen`:
  - Reset value 0, forced asynchronously on the falling edge of `rst_n`.
  - Becomes 1 on the first `clk` rising edge with `illegal`=1 after `rst_n` is released.
  - Reset wins over a simultaneous illegal decode.
- X or Z on the inputs may propagate; no masking is required.

## Test plan
- ADD (opcode 0110011, `funct3` 000, `funct7` 0000000), wait 10 ns -> `alu_op`=0000, `reg_we`=01, `alu_b_sel`=0, `wb_sel`=00; SUB (`funct7` 0100000) -> `alu_op`=0001.
- ADDI (0010011/000) -> `alu_op`=0000, `reg_we`=01, `alu_b_sel`=1, `imm_sel`=00; SRAI (`funct3` 101, `funct7` 0100000) -> `alu_op`=0111.
- LW (0000011/010) -> `reg_we`=10, `wb_sel`=01, `mem_we`=0; SW (0100011/010) -> `mem_we`=1, `reg_we`=00, `imm_sel`=01.
- BEQ (1100011/000) -> `alu_op`=0000, `pc_sel`=0, `reg_we`=00, `imm_sel`=10.
- JAL (1101111) -> `pc_sel`=1, `reg_we`=01, `wb_sel`=10, `imm_sel`=11; JALR (1100111/000) -> `pc_sel`=1, `alu_a_sel`=0.
- Illegal-flag sequence:
  - Release `rst_n`, then apply opcode 1111111 -> `illegal`=1 with all other decode outputs 0.
  - `illegal_seen` becomes 1 at the next `clk` edge and stays 1 after switching to ADD.
  - Pulsing `rst_n` low clears `illegal_seen` immediately, without waiting for a clock edge.
